// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner.
// Drives one column low at a time, synchronises the row lines, debounces a
// single-key press and release, and emits one new_key pulse per press with
// the key's 5-bit code held on key_code until the next accepted press.
module keypad_scanner #(
  parameter int SCAN_TICKS      = 1000,
  parameter int DEBOUNCE_CYCLES = 20000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       new_key,
  output logic [4:0] key_code
);

  localparam int MAX_CNT = (SCAN_TICKS > DEBOUNCE_CYCLES) ? SCAN_TICKS : DEBOUNCE_CYCLES;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_TICKS - 1);
  localparam logic [CW-1:0] DEB_LAST  = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2
  } state_t;

  state_t          state_r;
  logic [3:0]      row_meta_r;
  logic [3:0]      rs_r;
  logic [3:0]      col_r;
  logic [1:0]      col_idx_r;
  logic [1:0]      row_idx_r;
  logic [3:0]      pat_r;
  logic [CW-1:0]   cnt_r;
  logic            new_key_r;
  logic [4:0]      key_code_r;

  // True when exactly one row line is pulled low; multi-row patterns are ghosts.
  function automatic logic single_low(input logic [3:0] v);
    case (v)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single_low = 1'b1;
      default:                            single_low = 1'b0;
    endcase
  endfunction

  // Index of the single low row line.
  function automatic logic [1:0] low_index(input logic [3:0] v);
    case (v)
      4'b1110: low_index = 2'd0;
      4'b1101: low_index = 2'd1;
      4'b1011: low_index = 2'd2;
      4'b0111: low_index = 2'd3;
      default: low_index = 2'd0;
    endcase
  endfunction

  // Physical key position to calculator key code.
  function automatic logic [4:0] key_map(input logic [1:0] r, input logic [1:0] c);
    case ({r, c})
      4'd0:    key_map = 5'b10001; // '1'
      4'd1:    key_map = 5'b10010; // '2'
      4'd2:    key_map = 5'b10011; // '3'
      4'd3:    key_map = 5'b00010; // '+'
      4'd4:    key_map = 5'b10100; // '4'
      4'd5:    key_map = 5'b10101; // '5'
      4'd6:    key_map = 5'b10110; // '6'
      4'd7:    key_map = 5'b00011; // '-'
      4'd8:    key_map = 5'b10111; // '7'
      4'd9:    key_map = 5'b11000; // '8'
      4'd10:   key_map = 5'b11001; // '9'
      4'd11:   key_map = 5'b00100; // '*'
      4'd12:   key_map = 5'b00101; // 'C'
      4'd13:   key_map = 5'b10000; // '0'
      4'd14:   key_map = 5'b00001; // '='
      4'd15:   key_map = 5'b00110; // '/'
      default: key_map = 5'b00000;
    endcase
  endfunction

  // Two-flop synchroniser for the asynchronous row lines (idle level is high).
  always_ff @(posedge clk) begin
    if (reset) begin
      row_meta_r <= 4'b1111;
      rs_r       <= 4'b1111;
    end else begin
      row_meta_r <= row;
      rs_r       <= row_meta_r;
    end
  end

  // Scan / debounce / hold state machine with registered column and key outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= SCAN;
      col_r      <= 4'b1110;
      col_idx_r  <= 2'd0;
      row_idx_r  <= 2'd0;
      pat_r      <= 4'b1111;
      cnt_r      <= CNT_ZERO;
      new_key_r  <= 1'b0;
      key_code_r <= 5'b00000;
    end else begin
      new_key_r <= 1'b0;
      case (state_r)
        SCAN: begin
          if (cnt_r == SCAN_LAST) begin
            cnt_r <= CNT_ZERO;
            if (single_low(rs_r)) begin
              pat_r     <= rs_r;
              row_idx_r <= low_index(rs_r);
              state_r   <= DEBOUNCE;
            end else begin
              col_r     <= {col_r[2:0], col_r[3]};
              col_idx_r <= col_idx_r + 2'd1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        DEBOUNCE: begin
          if (rs_r != pat_r) begin
            // Bounce or a different key: abandon this column.
            col_r     <= {col_r[2:0], col_r[3]};
            col_idx_r <= col_idx_r + 2'd1;
            cnt_r     <= CNT_ZERO;
            state_r   <= SCAN;
          end else if (cnt_r == DEB_LAST) begin
            new_key_r  <= 1'b1;
            key_code_r <= key_map(row_idx_r, col_idx_r);
            cnt_r      <= CNT_ZERO;
            state_r    <= HELD;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        HELD: begin
          // Only an unbroken run of fully released cycles ends the press.
          if (rs_r == 4'b1111) begin
            if (cnt_r == DEB_LAST) begin
              col_r     <= {col_r[2:0], col_r[3]};
              col_idx_r <= col_idx_r + 2'd1;
              cnt_r     <= CNT_ZERO;
              state_r   <= SCAN;
            end else begin
              cnt_r <= cnt_r + CNT_ONE;
            end
          end else begin
            cnt_r <= CNT_ZERO;
          end
        end
        default: begin
          state_r   <= SCAN;
          col_r     <= 4'b1110;
          col_idx_r <= 2'd0;
          cnt_r     <= CNT_ZERO;
        end
      endcase
    end
  end

  assign col      = col_r;
  assign new_key  = new_key_r;
  assign key_code = key_code_r;

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed and randomized bench for keypad_scanner.
// A physical keypad model pulls rows low from a pressed-key matrix and the
// driven column; expected codes come from the printed key layout.
module tb_keypad_scanner;

  localparam int ST = 4;
  localparam int DB = 8;

  logic       clk   = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] row   = 4'b1111;
  logic [3:0] col;
  logic       new_key;
  logic [4:0] key_code;

  keypad_scanner #(.SCAN_TICKS(ST), .DEBOUNCE_CYCLES(DB)) dut (
    .clk      (clk),
    .reset    (reset),
    .row      (row),
    .col      (col),
    .new_key  (new_key),
    .key_code (key_code)
  );

  always #5 clk = ~clk;

  bit         pressed [4][4];
  int         n_vec  = 0;
  int         n_err  = 0;
  int         pulses = 0;
  logic [4:0] last_code = 5'b00000;
  logic [4:0] prev_code = 5'b00000;
  logic       prev_nk   = 1'b0;
  string      layout    = "123+456-789*C0=/";

  // Key code derived from the face of the key.
  function automatic logic [4:0] exp_code(int r, int c);
    byte ch;
    ch = layout[r*4 + c];
    if (ch >= "0" && ch <= "9") return {1'b1, 4'(ch - "0")};
    case (ch)
      "=":     return 5'd1;
      "+":     return 5'd2;
      "-":     return 5'd3;
      "*":     return 5'd4;
      "C":     return 5'd5;
      "/":     return 5'd6;
      default: return 5'd0;
    endcase
  endfunction

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Keypad model: a pressed key shorts its row to the driven (low) column.
  task automatic drive_rows();
    logic [3:0] v;
    v = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (pressed[r][c] && col[c] === 1'b0) v[r] = 1'b0;
    row = v;
  endtask

  task automatic clear_keys();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        pressed[r][c] = 1'b0;
  endtask

  // One clock: sample outputs just after the edge, run invariants, update rows.
  task automatic tick();
    bit rst_edge;
    rst_edge = reset;
    @(posedge clk);
    #1;
    chk("col_onehot_low", 32'($countones(~col)), 32'd1);
    chk("no_double_pulse", {31'd0, (new_key === 1'b1 && prev_nk === 1'b1)}, 32'd0);
    if (!rst_edge && new_key !== 1'b1) chk("code_hold", {27'd0, key_code}, {27'd0, prev_code});
    if (new_key === 1'b1) begin
      pulses++;
      last_code = key_code;
    end
    prev_nk   = new_key;
    prev_code = key_code;
    drive_rows();
  endtask

  task automatic press(int r, int c, int hold, int gap, string tag);
    int p0;
    p0 = pulses;
    pressed[r][c] = 1'b1;
    repeat (hold) tick();
    pressed[r][c] = 1'b0;
    repeat (gap) tick();
    chk({tag, "_count"}, 32'(pulses - p0), 32'd1);
    chk({tag, "_code"}, {27'd0, last_code}, {27'd0, exp_code(r, c)});
  endtask

  // Free-running rotation after a reset edge: column k/4 mod 4 is low.
  task automatic rotation(string tag);
    logic [3:0] e;
    int p0;
    p0 = pulses;
    for (int k = 1; k <= 40; k++) begin
      tick();
      e = ~(4'b0001 << ((k / ST) % 4));
      chk({tag, "_col"}, {28'd0, col}, {28'd0, e});
    end
    chk({tag, "_nopulse"}, 32'(pulses - p0), 32'd0);
  endtask

  initial begin
    int p0;
    clear_keys();

    // Reset state.
    reset = 1'b1;
    tick();
    tick();
    chk("rst_col", {28'd0, col}, 32'hE);
    chk("rst_new_key", {31'd0, new_key}, 32'd0);
    chk("rst_key_code", {27'd0, key_code}, 32'd0);
    reset = 1'b0;

    // Idle scanning.
    rotation("idle");
    chk("idle_key_code", {27'd0, key_code}, 32'd0);

    // Ghost: two rows low on column 0 is never accepted.
    pressed[0][0] = 1'b1;
    pressed[1][0] = 1'b1;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rotation("ghost");
    clear_keys();
    repeat (12) tick();

    // '8' held 40 cycles, then release timing.
    p0 = pulses;
    pressed[2][1] = 1'b1;
    repeat (40) tick();
    chk("eight_count", 32'(pulses - p0), 32'd1);
    chk("eight_code", {27'd0, last_code}, {27'd0, exp_code(2, 1)});
    pressed[2][1] = 1'b0;
    tick();
    repeat (9) tick();
    chk("eight_frozen_col", {28'd0, col}, 32'hD);
    tick();
    chk("eight_resume_col", {28'd0, col}, 32'hB);
    chk("eight_code_kept", {27'd0, key_code}, 32'h18);
    repeat (10) tick();

    // '=' then '-'.
    press(3, 2, 40, 20, "equals");
    press(1, 3, 40, 20, "minus");

    // Bounce on '1' then a stable hold.
    p0 = pulses;
    for (int i = 0; i < 10; i++) begin
      pressed[0][0] = (i % 2 == 0);
      repeat (3) tick();
    end
    chk("bounce_nopulse", 32'(pulses - p0), 32'd0);
    press(0, 0, 30, 20, "bounce_hold");

    // Randomized presses.
    for (int n = 0; n < 8; n++) begin
      press($urandom_range(0, 3), $urandom_range(0, 3),
            $urandom_range(30, 45), $urandom_range(14, 24), "rand");
    end

    // Reset while HELD with the key still down.
    p0 = pulses;
    pressed[0][0] = 1'b1;
    for (int i = 0; i < 40 && pulses == p0; i++) tick();
    chk("held_first_pulse", 32'(pulses - p0), 32'd1);
    repeat (3) tick();
    reset = 1'b1;
    tick();
    chk("held_rst_col", {28'd0, col}, 32'hE);
    chk("held_rst_new_key", {31'd0, new_key}, 32'd0);
    chk("held_rst_key_code", {27'd0, key_code}, 32'd0);
    reset = 1'b0;
    p0 = pulses;
    repeat (40) tick();
    chk("post_rst_count", 32'(pulses - p0), 32'd1);
    chk("post_rst_code", {27'd0, last_code}, 32'h11);
    clear_keys();
    repeat (15) tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
